// File: rtl/poly_tmul_seq.sv
// Sequencer for c = h * r in Z_q[x]/(x^N - 1), q = 2^W, r ternary.
// One coefficient of c is produced every N+2 cycles using a single carry-select adder.
module poly_tmul_seq #(
  parameter int N  = 701,
  parameter int W  = 13,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] h_addr,
  input  logic [W-1:0]  h_rdata,
  output logic [AW-1:0] r_addr,
  input  logic [1:0]    r_rdata,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [W-1:0]  c_wdata
);

  // Handshake: start is sampled only while idle (busy=0). busy then stays high
  // through the DONE cycle. done pulses for exactly one cycle per completed run.
  // Requests made while busy are dropped.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam int LW = W / 2;
  localparam int HW = W - LW;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          valid_q, valid_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          c_we_q, c_we_d;
  logic [AW-1:0] h_addr_q, h_addr_d;
  logic [AW-1:0] r_addr_q, r_addr_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [W-1:0]  c_wdata_q, c_wdata_d;

  // Ternary operand select: +h, ~h with carry-in (i.e. -h), or zero.
  logic [W-1:0] opnd_b;
  logic         cin;

  always_comb begin
    opnd_b = '0;
    cin    = 1'b0;
    case (r_rdata)
      2'b01: begin
        opnd_b = h_rdata;
      end
      2'b11: begin
        opnd_b = h_rdata ^ {W{1'b1}};
        cin    = 1'b1;
      end
      default: begin
        opnd_b = '0;
        cin    = 1'b0;
      end
    endcase
  end

  // Carry-select adder: the upper half is precomputed for both carries.
  logic [LW:0]   sum_lo;
  logic [HW-1:0] sum_hi0;
  logic [HW-1:0] sum_hi1;
  logic [W-1:0]  sum;

  always_comb begin
    sum_lo  = {1'b0, acc_q[LW-1:0]} + {1'b0, opnd_b[LW-1:0]} + {{LW{1'b0}}, cin};
    sum_hi0 = acc_q[W-1:LW] + opnd_b[W-1:LW];
    sum_hi1 = acc_q[W-1:LW] + opnd_b[W-1:LW] + HW'(1);
    sum     = {(sum_lo[LW] ? sum_hi1 : sum_hi0), sum_lo[LW-1:0]};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    valid_d = valid_q;

    // Data issued last cycle arrives now; fold it in.
    if (valid_q) begin
      acc_d = sum;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_RUN: begin
        i_d     = i_q + AW'(1);
        j_d     = (j_q == '0) ? LAST : j_q - AW'(1);
        valid_d = 1'b1;
        if (i_q == LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        acc_d = '0;
        i_d   = '0;
        if (k_q == LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + AW'(1);
          j_d     = k_q + AW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up with the state.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    c_we_d    = (state_d == S_WRITE);
    c_addr_d  = c_we_d ? k_d : '0;
    c_wdata_d = c_we_d ? acc_d : '0;
    h_addr_d  = (state_d == S_RUN) ? i_d : '0;
    r_addr_d  = (state_d == S_RUN) ? j_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_we_q    <= 1'b0;
      h_addr_q  <= '0;
      r_addr_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_we_q    <= c_we_d;
      h_addr_q  <= h_addr_d;
      r_addr_q  <= r_addr_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_we    = c_we_q;
  assign h_addr  = h_addr_q;
  assign r_addr  = r_addr_q;
  assign c_addr  = c_addr_q;
  assign c_wdata = c_wdata_q;

endmodule
